// File: rtl/jt12_mod_sum.sv
// Phase-modulation summing stage of the JT12 operator pipeline: records every
// slot result, keeps S1 feedback history per channel and forms the next slot's modulation word.
module jt12_mod_sum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        zero,
    input  logic [13:0] op_result,
    input  logic        s1_enters,
    input  logic        use_prev1,
    input  logic        use_prev2,
    input  logic        use_prevprev1,
    input  logic        use_internal_x,
    input  logic        use_internal_y,
    input  logic [2:0]  fb_I,
    output logic [9:0]  mod_out
);

    logic [4:0]         cnt_r;
    logic [13:0]        hist_r [1:17];
    logic [13:0]        fa_r   [0:5];
    logic [13:0]        fb_r   [0:5];
    logic [2:0]         rc_s;
    logic [13:0]        fa_rd_s;
    logic [13:0]        fb_rd_s;
    logic signed [14:0] fsum_s;
    logic [9:0]         fmod_s;
    logic signed [15:0] opa_s;
    logic signed [15:0] opb_s;
    logic signed [15:0] opc_s;
    logic signed [15:0] sum_s;
    logic [9:0]         next_mod_s;

    // Read channel for the next slot; 6 marks "not an S1 slot" and reads as zero.
    always_comb begin
        rc_s = 3'd0;
        if (zero || (cnt_r == 5'd23)) begin
            rc_s = 3'd0;
        end else if (cnt_r < 5'd5) begin
            rc_s = cnt_r[2:0] + 3'd1;
        end else begin
            rc_s = 3'd6;
        end
    end

    // Feedback memory read mux.
    always_comb begin
        fa_rd_s = 14'd0;
        fb_rd_s = 14'd0;
        case (rc_s)
            3'd0: begin fa_rd_s = fa_r[0]; fb_rd_s = fb_r[0]; end
            3'd1: begin fa_rd_s = fa_r[1]; fb_rd_s = fb_r[1]; end
            3'd2: begin fa_rd_s = fa_r[2]; fb_rd_s = fb_r[2]; end
            3'd3: begin fa_rd_s = fa_r[3]; fb_rd_s = fb_r[3]; end
            3'd4: begin fa_rd_s = fa_r[4]; fb_rd_s = fb_r[4]; end
            3'd5: begin fa_rd_s = fa_r[5]; fb_rd_s = fb_r[5]; end
            default: begin fa_rd_s = 14'd0; fb_rd_s = 14'd0; end
        endcase
    end

    // Feedback sum and operand sum, then the select between them.
    always_comb begin
        fsum_s = $signed({fa_rd_s[13], fa_rd_s}) + $signed({fb_rd_s[13], fb_rd_s});
        fmod_s = 10'(fsum_s >>> (4'd9 - {1'b0, fb_I}));
        opa_s  = use_prev1 ? $signed({{2{hist_r[5][13]}}, hist_r[5]}) : 16'sd0;
        opb_s  = (use_prev2 | use_internal_x) ? $signed({{2{hist_r[11][13]}}, hist_r[11]}) : 16'sd0;
        opc_s  = (use_prevprev1 | use_internal_y) ? $signed({{2{hist_r[17][13]}}, hist_r[17]}) : 16'sd0;
        sum_s  = opa_s + opb_s + opc_s;
        if (s1_enters) begin
            if (fb_I == 3'd0) begin
                next_mod_s = 10'd0;
            end else begin
                next_mod_s = fmod_s;
            end
        end else begin
            next_mod_s = 10'(sum_s >>> 1);
        end
    end

    // Slot counter; zero realigns the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 5'd0;
        end else if (clk_en) begin
            if (zero || (cnt_r == 5'd23)) begin
                cnt_r <= 5'd0;
            end else begin
                cnt_r <= cnt_r + 5'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // History line: hist_r[k] holds the result of k slots ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= 17; k++) begin
                hist_r[k] <= 14'd0;
            end
        end else if (clk_en) begin
            hist_r[1] <= op_result;
            for (int k = 2; k <= 17; k++) begin
                hist_r[k] <= hist_r[k-1];
            end
        end
    end

    // S1 feedback memory: fa is the latest S1 output of a channel, fb the one before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 6; ch++) begin
                fa_r[ch] <= 14'd0;
                fb_r[ch] <= 14'd0;
            end
        end else if (clk_en) begin
            for (int ch = 0; ch < 6; ch++) begin
                if (cnt_r == 5'(ch)) begin
                    fb_r[ch] <= fa_r[ch];
                    fa_r[ch] <= op_result;
                end
            end
        end
    end

    // Registered modulation word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_out <= 10'd0;
        end else if (clk_en) begin
            mod_out <= next_mod_s;
        end else begin
            mod_out <= mod_out;
        end
    end

endmodule

// File: doc/jt12_mod_sum.md
# jt12_mod_sum

Phase-modulation summing stage for the JT12 FM operator pipeline. It records the operator output of every slot, keeps per-channel S1 feedback history, and forms the 10-bit phase-modulation word for the next operator slot. It sits downstream of the algorithm modulator-selection logic, consuming its `use_*` selects, and feeds the operator phase adder. One clock-enabled step is taken per slot of the 24-slot frame:

- Slots 0–5: S1, ch0–5
- Slots 6–11: S3, ch0–5
- Slots 12–17: S2, ch0–5
- Slots 18–23: S4, ch0–5

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — system clock; the only clock.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `clk_en`  in  1  — slot strobe; all state advances only when high.
- `zero`  in  1  — frame marker; high with `clk_en` when `op_result` is from slot 23.
- `op_result`  in  14  — signed operator output of the slot just finished (slot n).
- `s1_enters`  in  1  — next slot (n+1) belongs to group S1.
- `use_prev1`, `use_prev2`, `use_prevprev1`, `use_internal_x`, `use_internal_y`  in  1 each  — operand selects for slot n+1.
- `fb_I`  in  3  — S1 feedback level, 0..7.
- `mod_out`  out  10  — phase-modulation word for slot n+1.

## Operation
**Slot counter `cnt`**
- 5 bits, range 0..23; `cnt` is the index of the slot whose result is on `op_result`.
- On `clk_en`: if `zero`, `cnt <= 0`; else if `cnt == 23`, `cnt <= 0`; else `cnt <= cnt + 1`.
- `zero` therefore realigns the frame every time it is asserted.

**History line**
- 17-entry × 14-bit shift register. Define `hist[0] = op_result` and `hist[k]` = result of slot n−k.
- On `clk_en`, shift in `op_result`.
- Taps for slot n+1: `A = hist[5]`, `B = hist[11]`, `C = hist[17]`. These are the same channel's outputs 1, 2 and 3 groups earlier.

**Feedback memory**
- 6 channels × 2 entries × 14 bits, named `fa`/`fb`.
- On `clk_en` with `cnt ≤ 5`: `fb[cnt] <= fa[cnt]`, then `fa[cnt] <= op_result`.
- Read channel `rc` is the channel of slot n+1:
  - `rc = 0` when `zero` is high or `cnt == 23`.
  - Otherwise `rc = cnt + 1`; this is only used when `cnt + 1 ≤ 5`.
- Read-during-write is not possible: the read channel is never the channel being written.

**Sum, computed on `clk_en` and registered into `mod_out`**
- If `s1_enters`:
  - `fsum = fa[rc] + fb[rc]`, 15-bit signed.
  - If `fb_I == 0`, `mod_out = 0`.
  - Otherwise `mod_out = (fsum >>> (9 − fb_I))[9:0]`, an arithmetic shift of 8..2.
- Otherwise:
  - `sum = (use_prev1 ? A : 0) + ((use_prev2 | use_internal_x) ? B : 0) + ((use_prevprev1 | use_internal_y) ? C : 0)`.
  - All operands are sign-extended to 16 bits.
  - `mod_out = sum[10:1]`; wrap is modulo 1024 and no saturation is applied.
- When `s1_enters` is high, the non-feedback selects are ignored.
- The `s*_enters`/`use_*` inputs are trusted as given. No consistency check against `cnt` is made.

## Timing
- **Reset** (`rst_n` low, asynchronous): `cnt = 0`, all history and feedback entries = 0, `mod_out = 0`. Release is synchronous to `clk`.
- **Reset mid-frame:** all history is lost and the first frame after reset produces modulation from zeroed taps.
- **Latency:**
  - `mod_out` updates on the `clk` edge at which `clk_en` is high and is held until the next such edge.
  - The result of slot n is used in `mod_out` at the earliest 6 strobes later (tap A). Feedback uses it 24 strobes later.
- **`clk_en` low:** `cnt`, history, feedback memory and `mod_out` all hold.
- **Simultaneous `zero` and `cnt != 23`:** `zero` wins; `cnt` is forced to 0.
- Inputs are sampled only on `clk_en` edges and may change freely otherwise.

## Test plan
- **Reset:** assert `rst_n = 0` mid-stream → `mod_out = 0`, `cnt = 0` immediately. After release, 18 strobes with `use_prev1 = use_prev2 = use_prevprev1 = 1` and `op_result = 0` → `mod_out` stays 0.
- **Single tap:** drive `op_result = 1000` at slot 0, then 0. Set `use_prev1 = 1` only. At the strobe with `cnt = 5` → `mod_out = 500` (0x1F4).
- **Wrap:** set A = B = C = 8191 with all selects high → `sum = 24573`, `mod_out = 0x3FE` (1022). Set A = −8192 alone → `mod_out = 0x000` (−4096 mod 1024).
- **Feedback:**
  - Over two frames, drive S1 ch2 results of 256 and 256. Then, at the strobe with `cnt = 1`, `s1_enters = 1`, `fb_I = 7` → `mod_out = 128`.
  - Same setup with `fb_I = 0` → `mod_out = 0`.
  - Same setup with `fb_I = 1` → `mod_out = 2`.
- **Enable gating and realign:**
  - Hold `clk_en = 0` for 10 clocks → no output or state change.
  - Assert `zero` at `cnt = 7` → next `cnt = 0`, and the feedback write goes to channel 0.
- **Select override:** `s1_enters = 1` with `use_prev2 = 1` and B = 4000, feedback entries 0, `fb_I = 3` → `mod_out = 0`.
